ex_stage: RTL and testbench

//  Execute stage of the 5-stage RV32 pipeline, directly upstream of the MEM stage; owns the EX/MEM pipeline register.

---
 rtl/ex_pkg.sv | 23 ++
 rtl/ex_stage_if.sv | 34 +++
 rtl/serial_divider.sv | 70 +++++++
 rtl/ex_stage.sv | 99 +++++++++
 tb/tb_ex_stage.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the RV32 execute stage: ALU op codes, divider states, width.
package ex_pkg;
    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_DIVU = 4'd10;
    localparam logic [3:0] ALU_REMU = 4'd11;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage.
interface ex_stage_if #(parameter int XLEN = ex_pkg::XLEN);
    logic            valid_in;
    logic            flush_in;
    logic [XLEN-1:0] PC_in;
    logic [XLEN-1:0] RegReadData1_in;
    logic [XLEN-1:0] RegReadData2_in;
    logic [XLEN-1:0] Imm_in;
    logic            ALUSrc_in;
    logic [3:0]      ALUOp_in;
    logic [4:0]      rd_in;
    logic            MemWrite_in, MemRead_in, RegWrite_in, MemToReg_in;

    logic [XLEN-1:0] PC_out;
    logic [XLEN-1:0] ALU_result_out;
    logic [XLEN-1:0] RegReadData2_out;
    logic [4:0]      rd_out;
    logic            MemWrite_out, MemRead_out, RegWrite_out, MemToReg_out;
    logic            stall_out;

    modport master (
        output valid_in, flush_in, PC_in, RegReadData1_in, RegReadData2_in, Imm_in,
               ALUSrc_in, ALUOp_in, rd_in, MemWrite_in, MemRead_in, RegWrite_in, MemToReg_in,
        input  PC_out, ALU_result_out, RegReadData2_out, rd_out,
               MemWrite_out, MemRead_out, RegWrite_out, MemToReg_out, stall_out
    );

    modport slave (
        input  valid_in, flush_in, PC_in, RegReadData1_in, RegReadData2_in, Imm_in,
               ALUSrc_in, ALUOp_in, rd_in, MemWrite_in, MemRead_in, RegWrite_in, MemToReg_in,
        output PC_out, ALU_result_out, RegReadData2_out, rd_out,
               MemWrite_out, MemRead_out, RegWrite_out, MemToReg_out, stall_out
    );
endinterface

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per clock; divide-by-zero falls out
// naturally as quotient all-ones and remainder = dividend.
module serial_divider
    import ex_pkg::*;
#(
    parameter int XLEN = ex_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] q_q, r_q, d_q;
    logic [XLEN:0]   rem_shift, diff;
    logic            ge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (cnt_q == CNT_W'(XLEN - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Shift the next dividend bit into the partial remainder and subtract if it fits.
    assign rem_shift = {r_q, q_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, d_q};
    assign ge        = rem_shift >= {1'b0, d_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
        end else if (state_q == IDLE && start && !abort) begin
            cnt_q <= '0;
            q_q   <= dividend;
            r_q   <= '0;
            d_q   <= divisor;
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + CNT_W'(1);
            q_q   <= {q_q[XLEN-2:0], ge};
            r_q   <= ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        end
    end

    assign busy      = (state_q == BUSY);
    assign done      = (state_q == DONE);
    assign quotient  = q_q;
    assign remainder = r_q;
endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: operand mux, ALU, iterative DIVU/REMU with upstream stall,
// and the EX/MEM pipeline register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = ex_pkg::XLEN
) (
    input logic          clk,
    input logic          rst_n,
    ex_stage_if.slave    ex
);
    localparam int SHW = $clog2(XLEN);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            mem_write;
        logic            mem_read;
        logic            reg_write;
        logic            mem_to_reg;
    } exmem_t;

    logic [XLEN-1:0] op_a, op_b, alu_res, div_q, div_r;
    logic [SHW-1:0]  shamt;
    logic            is_div, div_start, div_busy, div_done, stall;
    exmem_t          exmem_d, exmem_q;

    assign op_a   = ex.RegReadData1_in;
    assign op_b   = ex.ALUSrc_in ? ex.Imm_in : ex.RegReadData2_in;
    assign shamt  = op_b[SHW-1:0];
    assign is_div = is_div_op(ex.ALUOp_in);

    // The divider only accepts work while idle; a flush on the same edge wins.
    assign div_start = ex.valid_in && is_div && !ex.flush_in && !div_busy && !div_done;
    assign stall     = ex.valid_in && is_div && !div_done;

    serial_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (ex.flush_in),
        .dividend  (op_a),
        .divisor   (op_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        alu_res = '0;
        case (ex.ALUOp_in)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_DIVU: alu_res = div_q;
            ALU_REMU: alu_res = div_r;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        exmem_d = '0;
        if (ex.valid_in && !stall && !ex.flush_in) begin
            exmem_d.pc         = ex.PC_in;
            exmem_d.alu_result = alu_res;
            exmem_d.store_data = ex.RegReadData2_in;
            exmem_d.rd         = ex.rd_in;
            exmem_d.mem_write  = ex.MemWrite_in;
            exmem_d.mem_read   = ex.MemRead_in;
            exmem_d.reg_write  = ex.RegWrite_in;
            exmem_d.mem_to_reg = ex.MemToReg_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) exmem_q <= '0;
        else        exmem_q <= exmem_d;
    end

    assign ex.PC_out           = exmem_q.pc;
    assign ex.ALU_result_out   = exmem_q.alu_result;
    assign ex.RegReadData2_out = exmem_q.store_data;
    assign ex.rd_out           = exmem_q.rd;
    assign ex.MemWrite_out     = exmem_q.mem_write;
    assign ex.MemRead_out      = exmem_q.mem_read;
    assign ex.RegWrite_out     = exmem_q.reg_write;
    assign ex.MemToReg_out     = exmem_q.mem_to_reg;
    assign ex.stall_out        = stall;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: randomized ALU and divider traffic against an
// arithmetic reference model, plus flush and asynchronous reset scenarios.
module tb_ex_stage;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_stage_if bus ();
    ex_stage dut (.clk(clk), .rst_n(rst_n), .ex(bus));

    int checks = 0;
    int errors = 0;

    // Reference: the ISA meaning of each op code, written as plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'($signed(a) >>> b[4:0]);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd11:   return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic outputs_zero();
        return (bus.PC_out == 0) && (bus.ALU_result_out == 0) && (bus.RegReadData2_out == 0) &&
               (bus.rd_out == 0) && !bus.MemWrite_out && !bus.MemRead_out &&
               !bus.RegWrite_out && !bus.MemToReg_out;
    endfunction

    task automatic idle_inputs();
        bus.valid_in = 0; bus.flush_in = 0; bus.PC_in = 0; bus.RegReadData1_in = 0;
        bus.RegReadData2_in = 0; bus.Imm_in = 0; bus.ALUSrc_in = 0; bus.ALUOp_in = 0;
        bus.rd_in = 0; bus.MemWrite_in = 0; bus.MemRead_in = 0; bus.RegWrite_in = 0;
        bus.MemToReg_in = 0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [3:0] ctrl,
                         input logic [4:0] rd, input logic [31:0] pc);
        bus.valid_in = 1; bus.flush_in = 0; bus.ALUOp_in = op; bus.RegReadData1_in = a;
        bus.RegReadData2_in = b; bus.Imm_in = imm; bus.ALUSrc_in = src; bus.rd_in = rd;
        bus.PC_in = pc;
        {bus.MemWrite_in, bus.MemRead_in, bus.RegWrite_in, bus.MemToReg_in} = ctrl;
    endtask

    // Presents one single-cycle op and returns what EX/MEM holds one edge later.
    task automatic run_single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic src, input logic [3:0] ctrl,
                              output logic [31:0] res, output logic [31:0] st_data,
                              output logic [3:0] ctrl_o, output logic stall_seen);
        @(negedge clk);
        drive(op, a, b, imm, src, ctrl, 5'd7, 32'h100);
        #1 stall_seen = bus.stall_out;
        @(negedge clk);
        res     = bus.ALU_result_out;
        st_data = bus.RegReadData2_out;
        ctrl_o  = {bus.MemWrite_out, bus.MemRead_out, bus.RegWrite_out, bus.MemToReg_out};
        idle_inputs();
    endtask

    // Presents a div op, counts stall cycles (bounded) and returns the captured result.
    task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic src, input logic [3:0] ctrl,
                           output int n, output logic [31:0] res, output logic [3:0] ctrl_o,
                           output logic bubbles_ok);
        @(negedge clk);
        drive(op, a, b, imm, src, ctrl, 5'd9, 32'h200);
        #1;
        n = 0;
        bubbles_ok = 1;
        while (bus.stall_out && n < 200) begin
            n++;
            if (n > 1 && !outputs_zero()) bubbles_ok = 0;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        res    = bus.ALU_result_out;
        ctrl_o = {bus.MemWrite_out, bus.MemRead_out, bus.RegWrite_out, bus.MemToReg_out};
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        #1;
        checks++;
        if (!outputs_zero() || bus.stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: outputs_zero=%0b stall=%0b, required 1 and 0", outputs_zero(), bus.stall_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_single_cycle();
        logic [3:0] ops[$]; logic [31:0] as[$], bs[$], imms[$]; logic srcs[$];
        logic [31:0] res, sd, exp; logic [3:0] ctrl, co; logic st;
        ops = '{4'd0, 4'd7, 4'd8, 4'd9, 4'd13};
        as  = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
        bs  = '{32'd99, 32'd4, 32'd1, 32'd1, 32'd3};
        imms = '{32'd7, 32'd0, 32'd0, 32'd0, 32'd0};
        srcs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op = 4'($urandom_range(0, 15));
            if (is_div_op(op)) op = 4'd1;
            ops.push_back(op); as.push_back($urandom); bs.push_back($urandom);
            imms.push_back($urandom); srcs.push_back(1'($urandom_range(0, 1)));
        end
        foreach (ops[i]) begin
            ctrl = (i == 0) ? 4'b0010 : 4'($urandom);
            run_single(ops[i], as[i], bs[i], imms[i], srcs[i], ctrl, res, sd, co, st);
            exp = ref_alu(ops[i], as[i], srcs[i] ? imms[i] : bs[i]);
            checks++;
            if (res !== exp || sd !== bs[i] || co !== ctrl || st !== 1'b0) begin
                errors++;
                $display("FAIL alu_op%0d[%0d]: res=%h sd=%h ctrl=%b stall=%b, required res=%h sd=%h ctrl=%b stall=0",
                         ops[i], i, res, sd, co, st, exp, bs[i], ctrl);
            end
        end
        @(negedge clk);
        checks++;
        if (!outputs_zero()) begin
            errors++;
            $display("FAIL idle_bubble: ALU_result_out=%h RegWrite_out=%b, required all zero", bus.ALU_result_out, bus.RegWrite_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] a, b;
        logic [3:0] op;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (bus.ALU_result_out !== exp_q[0]) begin
                    errors++;
                    $display("FAIL back_to_back[%0d]: ALU_result_out=%h, required %h", i - 1, bus.ALU_result_out, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            op = 4'($urandom_range(0, 9));
            a = $urandom; b = $urandom;
            drive(op, a, b, 32'd0, 1'b0, 4'b0010, 5'd3, 32'h300 + 32'(i));
            exp_q.push_back(ref_alu(op, a, b));
        end
        @(negedge clk);
        checks++;
        if (bus.ALU_result_out !== exp_q[0]) begin
            errors++;
            $display("FAIL back_to_back_last: ALU_result_out=%h, required %h", bus.ALU_result_out, exp_q[0]);
        end
        idle_inputs();
    endtask

    task automatic test_divide();
        logic [3:0] ops[$]; logic [31:0] as[$], bs[$];
        logic [31:0] res, exp; logic [3:0] co, ctrl; logic bok; int n;
        ops = '{ALU_DIVU, ALU_REMU, ALU_DIVU, ALU_REMU};
        as  = '{32'd100, 32'd100, 32'h1234, 32'h1234};
        bs  = '{32'd7, 32'd7, 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            ops.push_back((i % 2 == 0) ? ALU_DIVU : ALU_REMU);
            as.push_back($urandom);
            bs.push_back($urandom >> $urandom_range(0, 31));
        end
        foreach (ops[i]) begin
            ctrl = 4'($urandom) | 4'b0010;
            run_div(ops[i], as[i], bs[i], 32'd0, 1'b0, ctrl, n, res, co, bok);
            exp = ref_alu(ops[i], as[i], bs[i]);
            checks++;
            if (n != XLEN + 1 || res !== exp || co !== ctrl || !bok) begin
                errors++;
                $display("FAIL div_op%0d[%0d] a=%h b=%h: stall_cycles=%0d res=%h ctrl=%b bubbles_ok=%0b, required %0d %h %b 1",
                         ops[i], i, as[i], bs[i], n, res, co, bok, XLEN + 1, exp, ctrl);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res, sd; logic [3:0] co; logic st, bok; int n; logic leaked;
        // Flush on the 10th cycle of a DIVU.
        @(negedge clk);
        drive(ALU_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 4'b0010, 5'd4, 32'h400);
        repeat (9) @(negedge clk);
        bus.flush_in = 1;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (!outputs_zero() || bus.stall_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble: outputs_zero=%0b stall=%0b, required 1 and 0", outputs_zero(), bus.stall_out);
        end
        leaked = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.ALU_result_out == 32'd333) leaked = 1;
        end
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL flush_no_quotient: quotient 333 observed, required never");
        end
        run_single(ALU_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 4'b0010, res, sd, co, st);
        checks++;
        if (res !== 32'd7 || co !== 4'b0010) begin
            errors++;
            $display("FAIL flush_then_add: res=%h ctrl=%b, required 00000007 0010", res, co);
        end
        run_div(ALU_DIVU, 32'd77, 32'd7, 32'd0, 1'b0, 4'b0010, n, res, co, bok);
        checks++;
        if (n != XLEN + 1 || res !== 32'd11) begin
            errors++;
            $display("FAIL flush_then_div: stall_cycles=%0d res=%h, required %0d 0000000b", n, res, XLEN + 1);
        end
        // Flush together with a fresh div op and with a single-cycle op.
        @(negedge clk);
        drive(ALU_DIVU, 32'd50, 32'd5, 32'd0, 1'b0, 4'b0010, 5'd4, 32'h500);
        bus.flush_in = 1;
        @(negedge clk);
        drive(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 4'b1010, 5'd4, 32'h504);
        bus.flush_in = 1;
        #1;
        checks++;
        if (!outputs_zero()) begin
            errors++;
            $display("FAIL flush_div_start: ALU_result_out=%h, required all zero", bus.ALU_result_out);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (!outputs_zero()) begin
            errors++;
            $display("FAIL flush_add: ALU_result_out=%h MemWrite_out=%b, required all zero", bus.ALU_result_out, bus.MemWrite_out);
        end
        run_div(ALU_DIVU, 32'd90, 32'd9, 32'd0, 1'b0, 4'b0010, n, res, co, bok);
        checks++;
        if (n != XLEN + 1 || res !== 32'd10) begin
            errors++;
            $display("FAIL flush_start_then_div: stall_cycles=%0d res=%h, required %0d 0000000a", n, res, XLEN + 1);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res, sd, rs2; logic [3:0] co; logic st, bok; int n;
        @(negedge clk);
        drive(ALU_ADD, 32'd5, 32'd0, 32'd7, 1'b1, 4'b0010, 5'd1, 32'h600);
        @(posedge clk);
        #2;
        checks++;
        if (bus.ALU_result_out !== 32'd12) begin
            errors++;
            $display("FAIL pre_reset_add: ALU_result_out=%h, required 0000000c", bus.ALU_result_out);
        end
        rst_n = 0;
        #1;
        checks++;
        if (!outputs_zero()) begin
            errors++;
            $display("FAIL async_reset_clear: ALU_result_out=%h RegWrite_out=%b, required all zero", bus.ALU_result_out, bus.RegWrite_out);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        // Reset in the middle of a division.
        @(negedge clk);
        drive(ALU_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 4'b0010, 5'd2, 32'h700);
        repeat (10) @(negedge clk);
        #2 rst_n = 0;
        idle_inputs();
        #1;
        checks++;
        if (!outputs_zero() || bus.stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_div: outputs_zero=%0b stall=%0b, required 1 and 0", outputs_zero(), bus.stall_out);
        end
        @(negedge clk);
        rst_n = 1;
        rs2 = $urandom;
        run_single(ALU_ADD, 32'h40, rs2, 32'd4, 1'b1, 4'b1000, res, sd, co, st);
        checks++;
        if (res !== 32'h44 || sd !== rs2 || co !== 4'b1000) begin
            errors++;
            $display("FAIL store_after_reset: res=%h sd=%h ctrl=%b, required 00000044 %h 1000", res, sd, co, rs2);
        end
        run_div(ALU_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 4'b0010, n, res, co, bok);
        checks++;
        if (n != XLEN + 1 || res !== 32'd14) begin
            errors++;
            $display("FAIL div_after_reset: stall_cycles=%0d res=%h, required %0d 0000000e", n, res, XLEN + 1);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_back_to_back();
        test_divide();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end
endmodule
